// File: rtl/turbo_rsc_encoder.sv
// LTE constituent RSC encoder (feedback 13o, feedforward 15o) with 3-step
// trellis termination. Emits one BPSK-mapped systematic word followed by one
// parity word per trellis step, then 3 tail steps, so a block of K bits
// produces 2*(K+3) words.
//
// Handshake: a bit transfers on a rising clk edge where valid_bit && ready.
// ready is high only in DATA on the first cycle of each 2-cycle step, so a
// producer may hold valid_bit high and see one acceptance every 2 cycles.
// valid_out marks each output word; no back-pressure is applied to the output.
module turbo_rsc_encoder #(
    parameter logic signed [15:0] AMP     = 16'sd64,
    parameter int                 MIN_BLK = 40,
    parameter int                 MAX_BLK = 6144
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        blklen,
    input  logic               valid_blklen,
    input  logic               bit_in,
    input  logic               valid_bit,
    output logic               ready,
    output logic signed [15:0] out,
    output logic               valid_out,
    output logic               last_out,
    output logic               blk_err
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_BLK);
    localparam logic [15:0] MAX_LEN = 16'(MAX_BLK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t      state, state_n;
    logic        ph, ph_n;
    logic        s1, s2, s3;
    logic        s1_n, s2_n, s3_n;
    logic        z_hold, z_hold_n;
    logic [12:0] cnt, cnt_n;
    logic [12:0] k_len, k_len_n;
    logic [1:0]  tcnt, tcnt_n;
    logic signed [15:0] out_n;
    logic        valid_out_n, last_out_n, blk_err_n;

    logic        u_bit, fb_a, par_z, len_ok;

    function automatic logic signed [15:0] map_bit(input logic b);
        return b ? -AMP : AMP;
    endfunction

    // During termination the input is chosen so the feedback sum is zero,
    // which drives the shift register back to 000 in three steps.
    assign u_bit  = (state == TAIL) ? (s2 ^ s3) : bit_in;
    assign fb_a   = u_bit ^ s2 ^ s3;
    assign par_z  = fb_a ^ s1 ^ s3;
    assign len_ok = (blklen >= MIN_LEN) && (blklen <= MAX_LEN);
    assign ready  = (state == DATA) && !ph;

    // Next-state and registered-output logic for the encoder FSM.
    always_comb begin
        state_n     = state;
        ph_n        = ph;
        s1_n        = s1;
        s2_n        = s2;
        s3_n        = s3;
        z_hold_n    = z_hold;
        cnt_n       = cnt;
        k_len_n     = k_len;
        tcnt_n      = tcnt;
        out_n       = out;
        valid_out_n = 1'b0;
        last_out_n  = 1'b0;
        blk_err_n   = 1'b0;

        case (state)
            IDLE: begin
                // A strobe coinciding with the final word is dropped: the
                // block has not yet been released in that cycle.
                if (valid_blklen && !last_out) begin
                    if (len_ok) begin
                        k_len_n = blklen[12:0];
                        cnt_n   = 13'd0;
                        s1_n    = 1'b0;
                        s2_n    = 1'b0;
                        s3_n    = 1'b0;
                        ph_n    = 1'b0;
                        state_n = DATA;
                    end else begin
                        blk_err_n = 1'b1;
                    end
                end
            end
            DATA: begin
                if (!ph) begin
                    if (valid_bit) begin
                        out_n       = map_bit(u_bit);
                        valid_out_n = 1'b1;
                        z_hold_n    = par_z;
                        s3_n        = s2;
                        s2_n        = s1;
                        s1_n        = fb_a;
                        cnt_n       = cnt + 13'd1;
                        ph_n        = 1'b1;
                    end
                end else begin
                    out_n       = map_bit(z_hold);
                    valid_out_n = 1'b1;
                    ph_n        = 1'b0;
                    if (cnt == k_len) begin
                        state_n = TAIL;
                        tcnt_n  = 2'd0;
                    end
                end
            end
            TAIL: begin
                if (!ph) begin
                    out_n       = map_bit(u_bit);
                    valid_out_n = 1'b1;
                    z_hold_n    = par_z;
                    s3_n        = s2;
                    s2_n        = s1;
                    s1_n        = fb_a;
                    ph_n        = 1'b1;
                end else begin
                    out_n       = map_bit(z_hold);
                    valid_out_n = 1'b1;
                    ph_n        = 1'b0;
                    if (tcnt == 2'd2) begin
                        last_out_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        tcnt_n = tcnt + 2'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, trellis registers and output flops; reset abandons any block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ph        <= 1'b0;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            z_hold    <= 1'b0;
            cnt       <= 13'd0;
            k_len     <= 13'd0;
            tcnt      <= 2'd0;
            out       <= 16'sd0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            blk_err   <= 1'b0;
        end else begin
            state     <= state_n;
            ph        <= ph_n;
            s1        <= s1_n;
            s2        <= s2_n;
            s3        <= s3_n;
            z_hold    <= z_hold_n;
            cnt       <= cnt_n;
            k_len     <= k_len_n;
            tcnt      <= tcnt_n;
            out       <= out_n;
            valid_out <= valid_out_n;
            last_out  <= last_out_n;
            blk_err   <= blk_err_n;
        end
    end

endmodule

// File: tb/tb_turbo_rsc_encoder.sv
// Bench for turbo_rsc_encoder: directed blocks, an expected-word queue built
// from a bit-level RSC model, block-length error strobes and an async reset
// in the middle of a block.
module tb_turbo_rsc_encoder;

    logic               clk = 1'b0;
    logic               rst;
    logic [15:0]        blklen;
    logic               valid_blklen;
    logic               bit_in;
    logic               valid_bit;
    logic               ready;
    logic signed [15:0] out;
    logic               valid_out;
    logic               last_out;
    logic               blk_err;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic        blk_bits[0:6143];
    int          blk_words = 0;
    int          last_words = 0;
    int          blocks_done = 0;
    int          gap_cnt = 0;
    logic        in_block = 1'b0;
    logic [15:0] cap[0:7];

    turbo_rsc_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .blklen       (blklen),
        .valid_blklen (valid_blklen),
        .bit_in       (bit_in),
        .valid_bit    (valid_bit),
        .ready        (ready),
        .out          (out),
        .valid_out    (valid_out),
        .last_out     (last_out),
        .blk_err      (blk_err)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Hand-derived BPSK words: 0 -> +64 (0040), 1 -> -64 (ffc0).
    function automatic logic [15:0] map_bit(input logic b);
        return b ? 16'hffc0 : 16'h0040;
    endfunction

    // Reference RSC: feedback 1+D^2+D^3, feedforward 1+D+D^3, 3 tail steps.
    task automatic build_expected(input int k);
        logic s1, s2, s3, u, a, z;
        s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
        for (int i = 0; i < k + 3; i++) begin
            u = (i < k) ? blk_bits[i] : (s2 ^ s3);
            a = u ^ s2 ^ s3;
            z = a ^ s1 ^ s3;
            exp_q.push_back(map_bit(u));
            exp_q.push_back(map_bit(z));
            s3 = s2; s2 = s1; s1 = a;
        end
    endtask

    // Output scoreboard: every valid word is popped and compared.
    always @(negedge clk) begin
        if (!rst) begin
            in_block  = 1'b0;
            blk_words = 0;
        end else if (valid_out) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", {16'd0, out}, 32'd0);
            end else begin
                check_val("out_word", {16'd0, out}, {16'd0, exp_q.pop_front()});
                check_val("last_out", {31'd0, last_out}, {31'd0, exp_q.size() == 0});
            end
            if (blk_words < 8) cap[blk_words] = out;
            blk_words++;
            in_block = 1'b1;
            if (last_out) begin
                last_words = blk_words;
                blk_words  = 0;
                in_block   = 1'b0;
                blocks_done++;
            end
        end else begin
            if (in_block) gap_cnt++;
            if (last_out) check_val("last_without_valid", 32'd1, 32'd0);
        end
    end

    task automatic strobe(input logic [15:0] k);
        @(posedge clk); #1;
        blklen       = k;
        valid_blklen = 1'b1;
        @(posedge clk); #1;
        valid_blklen = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit stall);
        logic ok;
        if (stall && ($urandom_range(0, 99) < 30)) begin
            valid_bit = 1'b0;
            @(posedge clk); #1;
        end
        valid_bit = 1'b1;
        bit_in    = b;
        ok        = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        if (!ok) begin
            check_val("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            check_val("ready_after_accept", {31'd0, ready}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic run_block(input int k, input bit stall);
        int done0;
        logic ok;
        build_expected(k);
        gap_cnt = 0;
        done0   = blocks_done;
        strobe(16'(k));
        for (int i = 0; i < k; i++) send_bit(blk_bits[i], stall);
        valid_bit = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(posedge clk); #1;
            if (blocks_done != done0) ok = 1'b1;
        end
        check_val("block_done", {31'd0, ok}, 32'd1);
        check_val("word_count", last_words, 2 * (k + 3));
        check_val("queue_empty", exp_q.size(), 32'd0);
        if (!stall) check_val("no_gaps", gap_cnt, 32'd0);
    endtask

    task automatic bad_len(input logic [15:0] k);
        @(posedge clk); #1;
        blklen       = k;
        valid_blklen = 1'b1;
        @(posedge clk); #1;
        valid_blklen = 1'b0;
        @(negedge clk);
        check_val("blk_err_pulse", {31'd0, blk_err}, 32'd1);
        check_val("ready_idle", {31'd0, ready}, 32'd0);
        check_val("no_valid_out", {31'd0, valid_out}, 32'd0);
        @(negedge clk);
        check_val("blk_err_clear", {31'd0, blk_err}, 32'd0);
        check_val("ready_idle2", {31'd0, ready}, 32'd0);
    endtask

    // Watchdog so the run always ends with a summary.
    initial begin
        #1000000;
        check_val("global_timeout", 32'd0, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        rst          = 1'b0;
        blklen       = 16'd0;
        valid_blklen = 1'b0;
        bit_in       = 1'b0;
        valid_bit    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out", {16'd0, out}, 32'd0);
        check_val("rst_valid", {31'd0, valid_out}, 32'd0);
        check_val("rst_last", {31'd0, last_out}, 32'd0);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_blk_err", {31'd0, blk_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // K=40 all zeros: every word +64, continuous output.
        for (int i = 0; i < 40; i++) blk_bits[i] = 1'b0;
        run_block(40, 1'b0);
        check_val("zero_w0", {16'd0, cap[0]}, 32'h0040);
        check_val("zero_w7", {16'd0, cap[7]}, 32'h0040);

        // K=40 impulse: hand-traced first four trellis steps.
        blk_bits[0] = 1'b1;
        run_block(40, 1'b0);
        check_val("imp_w0", {16'd0, cap[0]}, 32'hffc0);
        check_val("imp_w1", {16'd0, cap[1]}, 32'hffc0);
        check_val("imp_w2", {16'd0, cap[2]}, 32'h0040);
        check_val("imp_w3", {16'd0, cap[3]}, 32'hffc0);
        check_val("imp_w4", {16'd0, cap[4]}, 32'h0040);
        check_val("imp_w5", {16'd0, cap[5]}, 32'hffc0);
        check_val("imp_w6", {16'd0, cap[6]}, 32'h0040);
        check_val("imp_w7", {16'd0, cap[7]}, 32'hffc0);

        // Illegal lengths.
        bad_len(16'd39);
        bad_len(16'd6145);
        bad_len(16'd0);

        // K=512 random bits with 30% stalls, then K=6144 back to back.
        for (int i = 0; i < 512; i++) blk_bits[i] = 1'($urandom_range(0, 1));
        run_block(512, 1'b1);
        for (int i = 0; i < 6144; i++) blk_bits[i] = (((i * 13) % 7) < 3);
        run_block(6144, 1'b0);

        // Async reset in the middle of a K=512 block.
        for (int i = 0; i < 512; i++) blk_bits[i] = 1'(i % 3 == 0);
        build_expected(512);
        strobe(16'd512);
        for (int i = 0; i < 512; i++) begin
            send_bit(blk_bits[i], 1'b0);
            if (blk_words >= 300) break;
        end
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_out", {16'd0, out}, 32'd0);
        check_val("arst_valid", {31'd0, valid_out}, 32'd0);
        check_val("arst_ready", {31'd0, ready}, 32'd0);
        check_val("arst_last", {31'd0, last_out}, 32'd0);
        exp_q.delete();
        valid_bit = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("post_rst_idle", {31'd0, valid_out}, 32'd0);

        // Fresh K=40 block after reset starts from state 000.
        for (int i = 0; i < 40; i++) blk_bits[i] = 1'(i % 5 == 1);
        run_block(40, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
